// File: rtl/uart_command_parser_pkg.sv
// Shared command codes and state encodings for the UART command parser and its UART engines.
package uart_command_parser_pkg;

  localparam logic [7:0] READ_CMD  = 8'h00;
  localparam logic [7:0] WRITE_CMD = 8'hAA;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    VALUE,
    EXEC,
    WAIT_RDATA,
    RESP
  } parser_state_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_command_parser_rx.sv
// UART receiver: 2-flop synchronised line, start-bit recheck, LSB-first data, stop-bit validation.
module uart_command_parser_rx
  import uart_command_parser_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int DIVISOR      = 8,
  parameter int SAMPLE_PHASE = DIVISOR / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  valid
);

  localparam int CW = $clog2(DIVISOR);
  localparam int BW = $clog2(WORD_WIDTH);

  uart_state_t           state;
  logic                  rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [WORD_WIDTH-1:0] shreg;
  logic                  sample, bit_end;

  assign sample  = (cnt == CW'(SAMPLE_PHASE));
  assign bit_end = (cnt == CW'(DIVISOR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      state   <= UART_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      valid   <= 1'b0;
      if (state != UART_IDLE) cnt <= bit_end ? '0 : cnt + CW'(1);
      case (state)
        // The edge is seen during cycle 0 of the start bit, so the bit timer resumes at 1.
        UART_IDLE: if (rx_prev && !rx_s2) begin
          state <= UART_START;
          cnt   <= CW'(1);
        end
        UART_START: begin
          if (sample && rx_s2) state <= UART_IDLE;
          else if (bit_end) begin
            state   <= UART_DATA;
            bit_idx <= '0;
          end
        end
        UART_DATA: begin
          if (sample) shreg <= {rx_s2, shreg[WORD_WIDTH-1:1]};
          if (bit_end) begin
            if (bit_idx == BW'(WORD_WIDTH - 1)) state <= UART_STOP;
            else bit_idx <= bit_idx + BW'(1);
          end
        end
        UART_STOP: if (sample) begin
          state <= UART_IDLE;
          if (rx_s2) begin
            data  <= shreg;
            valid <= 1'b1;
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_command_parser_tx.sv
// UART transmitter with a valid/accept handshake; a byte offered at the end of a stop bit follows it directly.
module uart_command_parser_tx
  import uart_command_parser_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int DIVISOR    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [WORD_WIDTH-1:0] data,
  output logic                  accept,
  output logic                  tx
);

  localparam int CW = $clog2(DIVISOR);
  localparam int BW = $clog2(WORD_WIDTH);

  uart_state_t           state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [WORD_WIDTH-1:0] shreg;
  logic                  bit_end;

  assign bit_end = (cnt == CW'(DIVISOR - 1));

  always_comb begin
    accept = valid && (state == UART_IDLE || (state == UART_STOP && bit_end));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UART_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (accept) begin
      state <= UART_START;
      shreg <= data;
      cnt   <= '0;
      tx    <= 1'b0;
    end else begin
      if (state != UART_IDLE) cnt <= bit_end ? '0 : cnt + CW'(1);
      case (state)
        UART_START: if (bit_end) begin
          state   <= UART_DATA;
          bit_idx <= '0;
          tx      <= shreg[0];
        end
        UART_DATA: if (bit_end) begin
          if (bit_idx == BW'(WORD_WIDTH - 1)) begin
            state <= UART_STOP;
            tx    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + BW'(1);
            shreg   <= shreg >> 1;
            tx      <= shreg[1];
          end
        end
        UART_STOP: if (bit_end) state <= UART_IDLE;
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uart_command_parser.sv
// UART command parser: decodes WRITE/READ frames into register strobes and returns read data over UART.
module uart_command_parser
  import uart_command_parser_pkg::*;
#(
  parameter int WORD_WIDTH         = 8,
  parameter int VALUE_WORDS        = 4,
  parameter int PULSE_W_EN_MAX_LEN = 1,
  parameter int DIVISOR            = 8,
  parameter int SAMPLE_PHASE       = DIVISOR / 2
) (
  input  logic                              clk,
  input  logic                              i_reset,
  input  logic                              i_rx,
  output logic                              o_tx,
  output logic                              o_w_en,
  output logic [WORD_WIDTH-1:0]             o_w_addr,
  output logic [VALUE_WORDS*WORD_WIDTH-1:0] o_w_data,
  output logic                              o_r_en,
  output logic [WORD_WIDTH-1:0]             o_r_addr,
  input  logic [VALUE_WORDS*WORD_WIDTH-1:0] i_r_data,
  input  logic                              i_r_valid
);

  localparam int DW  = VALUE_WORDS * WORD_WIDTH;
  localparam int BCW = $clog2(VALUE_WORDS + 1);
  localparam int PCW = $clog2(PULSE_W_EN_MAX_LEN + 1);

  parser_state_t         state;
  logic [WORD_WIDTH-1:0] rx_data, cmd, addr, tx_data;
  logic                  rx_valid, tx_valid, tx_accept;
  logic                  is_write, is_read;
  logic [DW-1:0]         value, resp_data;
  logic [BCW-1:0]        byte_cnt, resp_cnt;
  logic [PCW-1:0]        pulse_cnt;
  logic [3:0]            wait_cnt;

  uart_command_parser_rx #(
    .WORD_WIDTH  (WORD_WIDTH),
    .DIVISOR     (DIVISOR),
    .SAMPLE_PHASE(SAMPLE_PHASE)
  ) u_rx (
    .clk  (clk),
    .rst_n(i_reset),
    .rx   (i_rx),
    .data (rx_data),
    .valid(rx_valid)
  );

  uart_command_parser_tx #(
    .WORD_WIDTH(WORD_WIDTH),
    .DIVISOR   (DIVISOR)
  ) u_tx (
    .clk   (clk),
    .rst_n (i_reset),
    .valid (tx_valid),
    .data  (tx_data),
    .accept(tx_accept),
    .tx    (o_tx)
  );

  assign is_write = (cmd == WORD_WIDTH'(WRITE_CMD));
  assign is_read  = (cmd == WORD_WIDTH'(READ_CMD));

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= CMD;
      cmd       <= '0;
      addr      <= '0;
      value     <= '0;
      byte_cnt  <= '0;
      pulse_cnt <= '0;
      wait_cnt  <= '0;
      resp_cnt  <= '0;
      resp_data <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      o_w_en    <= 1'b0;
      o_w_addr  <= '0;
      o_w_data  <= '0;
      o_r_en    <= 1'b0;
      o_r_addr  <= '0;
    end else begin
      case (state)
        CMD: if (rx_valid) begin
          cmd   <= rx_data;
          state <= ADDR;
        end
        ADDR: if (rx_valid) begin
          addr     <= rx_data;
          byte_cnt <= '0;
          state    <= VALUE;
        end
        // Strobes are raised on the last byte itself so they appear one cycle after it arrives.
        VALUE: if (rx_valid) begin
          value <= (value << WORD_WIDTH) | DW'(rx_data);
          if (byte_cnt == BCW'(VALUE_WORDS - 1)) begin
            state <= EXEC;
            if (is_write) begin
              o_w_en    <= 1'b1;
              o_w_addr  <= addr;
              o_w_data  <= (value << WORD_WIDTH) | DW'(rx_data);
              pulse_cnt <= '0;
            end else if (is_read) begin
              o_r_en   <= 1'b1;
              o_r_addr <= addr;
            end
          end else begin
            byte_cnt <= byte_cnt + BCW'(1);
          end
        end
        EXEC: begin
          if (is_write) begin
            if (pulse_cnt == PCW'(PULSE_W_EN_MAX_LEN - 1)) begin
              o_w_en <= 1'b0;
              state  <= CMD;
            end else begin
              pulse_cnt <= pulse_cnt + PCW'(1);
            end
          end else if (is_read) begin
            o_r_en   <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT_RDATA;
          end else begin
            state <= CMD;
          end
        end
        WAIT_RDATA: begin
          if (i_r_valid) begin
            tx_data   <= i_r_data[DW-1 -: WORD_WIDTH];
            resp_data <= i_r_data << WORD_WIDTH;
            tx_valid  <= 1'b1;
            resp_cnt  <= '0;
            state     <= RESP;
          end else if (wait_cnt == 4'd15) begin
            state <= CMD;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: if (tx_accept) begin
          if (resp_cnt == BCW'(VALUE_WORDS - 1)) begin
            tx_valid <= 1'b0;
            state    <= CMD;
          end else begin
            resp_cnt  <= resp_cnt + BCW'(1);
            tx_data   <= resp_data[DW-1 -: WORD_WIDTH];
            resp_data <= resp_data << WORD_WIDTH;
          end
        end
        default: state <= CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_command_parser.sv
// Scoreboard bench for uart_command_parser: frame-level reference model, UART line driver and decoder.
module tb_uart_command_parser;

  localparam int D  = 4;
  localparam int SP = 2;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_rx = 1'b1;
  logic        o_tx, o_w_en, o_r_en;
  logic [7:0]  o_w_addr, o_r_addr;
  logic [31:0] o_w_data;
  logic [31:0] i_r_data = '0;
  logic        i_r_valid = 1'b0;

  always #5 clk = ~clk;

  uart_command_parser #(
    .WORD_WIDTH        (8),
    .VALUE_WORDS       (4),
    .PULSE_W_EN_MAX_LEN(1),
    .DIVISOR           (D),
    .SAMPLE_PHASE      (SP)
  ) dut (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_rx     (i_rx),
    .o_tx     (o_tx),
    .o_w_en   (o_w_en),
    .o_w_addr (o_w_addr),
    .o_w_data (o_w_data),
    .o_r_en   (o_r_en),
    .o_r_addr (o_r_addr),
    .i_r_data (i_r_data),
    .i_r_valid(i_r_valid)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  longint      cyc = 0;
  logic [39:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [8:0]  tx_q[$];
  logic [31:0] model_mem[256];
  logic [31:0] rf_mem[256];
  int          rd_lat = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor; the register-file stand-in takes its contents from DUT writes.
  always @(negedge clk) begin : mon_strobe
    logic [39:0] we;
    logic [7:0]  re;
    if (i_reset) begin
      if (o_w_en && o_r_en) check("w_en_r_en_overlap", 1, 0);
      if (o_w_en) begin
        if (wr_q.size() == 0) check("unexpected_w_en", {56'd0, o_w_addr}, 64'hFFFF);
        else begin
          we = wr_q.pop_front();
          check("w_addr", o_w_addr, we[39:32]);
          check("w_data", o_w_data, we[31:0]);
        end
        rf_mem[o_w_addr] = o_w_data;
      end
      if (o_r_en) begin
        if (rd_q.size() == 0) check("unexpected_r_en", {56'd0, o_r_addr}, 64'hFFFF);
        else begin
          re = rd_q.pop_front();
          check("r_addr", o_r_addr, re);
        end
      end
    end
  end

  initial begin : responder
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (i_reset && o_r_en) begin
        a = o_r_addr;
        repeat (rd_lat) @(posedge clk);
        #1;
        i_r_data  = rf_mem[a];
        i_r_valid = 1'b1;
        @(posedge clk);
        #1;
        i_r_valid = 1'b0;
        i_r_data  = '0;
      end
    end
  end

  initial begin : mon_tx
    logic       prev;
    logic [7:0] b;
    logic       stop;
    logic [8:0] e;
    longint     st, last_st;
    prev = 1'b1;
    last_st = 0;
    forever begin
      @(negedge clk);
      if (i_reset && prev && !o_tx) begin
        st = cyc;
        repeat (D / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (D) @(negedge clk);
          b[i] = o_tx;
        end
        repeat (D) @(negedge clk);
        stop = o_tx;
        if (tx_q.size() == 0) check("unexpected_tx_byte", {56'd0, b}, 64'hFFFF);
        else begin
          e = tx_q.pop_front();
          check("tx_byte", b, e[7:0]);
          check("tx_stop_bit", stop, 1);
          if (e[8]) check("tx_frame_gap", st - last_st, 10 * D);
        end
        last_st = st;
        prev = 1'b1;
      end else begin
        prev = o_tx;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    i_rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (D) @(negedge clk);
    end
    i_rx = !bad_stop;
    repeat (D) @(negedge clk);
    if (bad_stop) begin
      i_rx = 1'b1;
      repeat (2 * D) @(negedge clk);
    end
  endtask

  // Reference: one completed 6-byte frame's effect on strobes and the reply stream.
  task automatic model_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] v);
    logic [31:0] r;
    if (c == 8'hAA) begin
      wr_q.push_back({a, v});
      model_mem[a] = v;
    end else if (c == 8'h00) begin
      rd_q.push_back(a);
      if (rd_lat >= 1 && rd_lat <= 15) begin
        r = model_mem[a];
        for (int k = 0; k < 4; k++) tx_q.push_back({k != 0, r[31-8*k -: 8]});
      end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((tx_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("drain_timeout", tx_q.size() + wr_q.size() + rd_q.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] v);
    model_frame(c, a, v);
    send_byte(c, 0);
    send_byte(a, 0);
    for (int k = 0; k < 4; k++) send_byte(v[31-8*k -: 8], 0);
    if (c == 8'h00) begin
      wait_drain();
      repeat (40) @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [23:0] lfsr;
    logic [7:0]  c;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = '0;
      rf_mem[i]    = '0;
    end
    repeat (5) @(negedge clk);
    check("reset_tx", o_tx, 1);
    check("reset_w_en", o_w_en, 0);
    check("reset_r_en", o_r_en, 0);
    check("reset_w_addr", o_w_addr, 0);
    check("reset_w_data", o_w_data, 0);
    check("reset_r_addr", o_r_addr, 0);
    i_reset = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hAA, 8'h05, 32'h12345678);
    repeat (10) @(negedge clk);
    check("hold_w_addr", o_w_addr, 8'h05);
    check("hold_w_data", o_w_data, 32'h12345678);
    check("hold_w_en_low", o_w_en, 0);

    send_frame(8'hAA, 8'hBB, 32'hDEADBEEF);
    send_frame(8'h00, 8'hBB, 32'h0);

    send_frame(8'h55, 8'h01, 32'hCAFEF00D);
    send_frame(8'hAA, 8'h10, 32'hA5A55A5A);

    // Address byte lost to a bad stop bit: frame regroups onto the following bytes.
    model_frame(8'hAA, 8'h21, 32'h22232499);
    send_byte(8'hAA, 0);
    send_byte(8'h77, 1);
    send_byte(8'h21, 0);
    send_byte(8'h22, 0);
    send_byte(8'h23, 0);
    send_byte(8'h24, 0);
    repeat (3 * D) @(negedge clk);
    check("bad_stop_no_early_strobe", wr_q.size(), 1);
    send_byte(8'h99, 0);
    repeat (3 * D) @(negedge clk);
    check("bad_stop_strobe_done", wr_q.size(), 0);

    send_byte(8'hAA, 0);
    send_byte(8'h33, 0);
    send_byte(8'h11, 0);
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_w_en", o_w_en, 0);
    check("midreset_w_addr", o_w_addr, 0);
    check("midreset_w_data", o_w_data, 0);
    check("midreset_tx", o_tx, 1);
    i_reset = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'hAA, 8'h34, 32'h0BADCAFE);

    rd_lat = 30;
    send_frame(8'h00, 8'h34, 32'hFFFFFFFF);
    check("timeout_no_tx", tx_q.size(), 0);
    rd_lat = 3;

    lfsr = 24'hACE1;
    for (int i = 0; i < 256; i++) begin
      lfsr = {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
      send_frame(8'hAA, 8'(i), {lfsr, 8'(i)});
    end
    send_frame(8'h00, 8'hFF, 32'h0);

    for (int n = 0; n < 12; n++) begin
      rd_lat = $urandom_range(1, 12);
      case ($urandom_range(0, 3))
        0: send_frame(8'h00, 8'($urandom), $urandom);
        1, 2: send_frame(8'hAA, 8'($urandom), $urandom);
        default: begin
          c = 8'($urandom);
          while (c == 8'h00 || c == 8'hAA) c = 8'($urandom);
          send_frame(c, 8'($urandom), $urandom);
        end
      endcase
    end

    wait_drain();
    repeat (20 * D) @(negedge clk);
    check("final_wr_q_empty", wr_q.size(), 0);
    check("final_rd_q_empty", rd_q.size(), 0);
    check("final_tx_q_empty", tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
